boid_plot_stream: RTL and testbench

Pixel-plotting stage that sits directly downstream of the boid accelerator's writeback. For each boid update it erases the boid's old pixel and draws its new pixel into the VGA M10k frame buffer through a stall-able single-port write interface. It emits a one-cycle `frame_done` pulse after every `N_BOIDS` updates so the control unit can pace frames.

---
 rtl/boid_pkg.sv | 17 +
 rtl/boid_plot_stream_pix_addr_gen.sv | 21 ++
 rtl/boid_plot_stream.sv | 154 +++++++++++++++
 tb/tb_boid_plot_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared types and defaults for the boid plotting pipeline.
package boid_pkg;

    typedef logic [31:0] fix16_t;

    localparam int unsigned H_RES_DEF      = 640;
    localparam int unsigned V_RES_DEF      = 480;
    localparam logic [7:0]  BOID_COLOR_DEF = 8'hFF;
    localparam logic [7:0]  BG_COLOR_DEF   = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } plot_state_t;

endpackage

// File: rtl/boid_plot_stream_pix_addr_gen.sv
// Integer pixel coordinate to linear frame-buffer address, plus off-screen flag.
module pix_addr_gen
    import boid_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned ADDR_W = 19
) (
    input  logic [15:0]       x_i,
    input  logic [15:0]       y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              clip_o
);

    localparam int unsigned FULL_W = 34;

    // Full-precision y*H_RES + x, truncated to the frame-buffer width.
    assign addr_o = ADDR_W'(FULL_W'(y_i) * FULL_W'(H_RES) + FULL_W'(x_i));
    assign clip_o = (32'(x_i) >= 32'(H_RES)) || (32'(y_i) >= 32'(V_RES));

endmodule

// File: rtl/boid_plot_stream.sv
// Erase-old / draw-new pixel writer with stall-able frame-buffer port and frame pacing.
// Define BOID_PLOT_TRAIL_EN to suppress erase writes (boids leave trails).
module boid_plot_stream
    import boid_pkg::*;
#(
    parameter int unsigned N_BOIDS    = 2,
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned ADDR_W     = 19,
    parameter logic [7:0]  BOID_COLOR = BOID_COLOR_DEF,
    parameter logic [7:0]  BG_COLOR   = BG_COLOR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  fix16_t            old_x,
    input  fix16_t            old_y,
    input  fix16_t            new_x,
    input  fix16_t            new_y,
    output logic              px_we,
    input  logic              px_grant,
    output logic [ADDR_W-1:0] px_addr,
    output logic [7:0]        px_data,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(N_BOIDS) + 1;

`ifdef BOID_PLOT_TRAIL_EN
    localparam bit TRAIL_EN = 1'b1;
`else
    localparam bit TRAIL_EN = 1'b0;
`endif

    plot_state_t       state_q, state_d;
    logic              px_we_q, px_we_d;
    logic [ADDR_W-1:0] px_addr_q, px_addr_d;
    logic [7:0]        px_data_q, px_data_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0] new_addr_q, new_addr_d;
    logic              new_clip_q, new_clip_d;

    logic [ADDR_W-1:0] old_addr, new_addr;
    logic              old_clip, new_clip;
    logic              same_pix, skip_erase, wr_done;
    logic              unused_frac;

    pix_addr_gen #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_old_addr (
        .x_i    (old_x[31:16]),
        .y_i    (old_y[31:16]),
        .addr_o (old_addr),
        .clip_o (old_clip)
    );

    pix_addr_gen #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_new_addr (
        .x_i    (new_x[31:16]),
        .y_i    (new_y[31:16]),
        .addr_o (new_addr),
        .clip_o (new_clip)
    );

    // Only integer parts select a pixel; fractional bits are intentionally dropped.
    assign unused_frac = ^{old_x[15:0], old_y[15:0], new_x[15:0], new_y[15:0]};
    assign same_pix    = (old_x[31:16] == new_x[31:16]) && (old_y[31:16] == new_y[31:16]);
    assign skip_erase  = old_clip || same_pix || TRAIL_EN;
    // A phase ends on grant, or immediately when it issues no write.
    assign wr_done     = !px_we_q || px_grant;

    always_comb begin
        state_d      = state_q;
        px_we_d      = px_we_q;
        px_addr_d    = px_addr_q;
        px_data_d    = px_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        new_addr_d   = new_addr_q;
        new_clip_d   = new_clip_q;
        case (state_q)
            IDLE: begin
                if (upd_valid) begin
                    state_d    = ERASE;
                    new_addr_d = new_addr;
                    new_clip_d = new_clip;
                    if (skip_erase) begin
                        px_we_d = 1'b0;
                    end else begin
                        px_we_d   = 1'b1;
                        px_addr_d = old_addr;
                        px_data_d = BG_COLOR;
                    end
                end
            end
            ERASE: begin
                if (wr_done) begin
                    state_d = DRAW;
                    if (new_clip_q) begin
                        px_we_d = 1'b0;
                    end else begin
                        px_we_d   = 1'b1;
                        px_addr_d = new_addr_q;
                        px_data_d = BOID_COLOR;
                    end
                end
            end
            DRAW: begin
                if (wr_done) begin
                    state_d = IDLE;
                    px_we_d = 1'b0;
                    if (frame_cnt_q == CNT_W'(N_BOIDS - 1)) begin
                        frame_cnt_d  = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                px_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            px_we_q      <= 1'b0;
            px_addr_q    <= '0;
            px_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            new_addr_q   <= '0;
            new_clip_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            px_we_q      <= px_we_d;
            px_addr_q    <= px_addr_d;
            px_data_q    <= px_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            new_addr_q   <= new_addr_d;
            new_clip_q   <= new_clip_d;
        end
    end

    assign upd_ready  = (state_q == IDLE);
    assign px_we      = px_we_q;
    assign px_addr    = px_addr_q;
    assign px_data    = px_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_boid_plot_stream.sv
// Self-checking bench for boid_plot_stream: write-slot reference model plus directed literals.
module tb_boid_plot_stream;

    localparam int unsigned N_BOIDS = 2;
    localparam int unsigned H       = 640;
    localparam int unsigned V       = 480;
    localparam int unsigned AW      = 19;
    localparam logic [7:0]  BOID_C  = 8'hFF;
    localparam logic [7:0]  BG_C    = 8'h00;

`ifdef BOID_PLOT_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [31:0]   old_x = '0, old_y = '0, new_x = '0, new_y = '0;
    logic          px_we;
    logic          px_grant = 1'b0;
    logic [AW-1:0] px_addr;
    logic [7:0]    px_data;
    logic          frame_done;

    boid_plot_stream #(.N_BOIDS(N_BOIDS)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .old_x      (old_x),
        .old_y      (old_y),
        .new_x      (new_x),
        .new_y      (new_y),
        .px_we      (px_we),
        .px_grant   (px_grant),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Each accepted update becomes two slots (erase, draw); a write slot lasts
    // until granted, a silent slot lasts one cycle.
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t         slots[$];
    int unsigned frame_cnt = 0;
    bit          fd_exp = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ref_addr(input int unsigned x, input int unsigned y);
        return AW'(y * H + x);
    endfunction

    task automatic model_step();
        int unsigned ox, oy, nx, ny;
        bit oclip, nclip, same;
        fd_exp = 1'b0;
        if (!rst_n) begin
            slots.delete();
            frame_cnt = 0;
            return;
        end
        if (slots.size() == 0) begin
            if (upd_valid) begin
                ox    = 32'(old_x[31:16]);
                oy    = 32'(old_y[31:16]);
                nx    = 32'(new_x[31:16]);
                ny    = 32'(new_y[31:16]);
                oclip = (ox >= H) || (oy >= V);
                nclip = (nx >= H) || (ny >= V);
                same  = (ox == nx) && (oy == ny);
                slots.push_back('{we: !(oclip || same || TRAIL), addr: ref_addr(ox, oy), data: BG_C});
                slots.push_back('{we: !nclip, addr: ref_addr(nx, ny), data: BOID_C});
            end
        end else if (!slots[0].we || px_grant) begin
            void'(slots.pop_front());
            if (slots.size() == 0) begin
                frame_cnt++;
                if (frame_cnt == N_BOIDS) begin
                    frame_cnt = 0;
                    fd_exp    = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_model();
        bit ew;
        ew = 1'b0;
        if (slots.size() != 0) ew = slots[0].we;
        check("upd_ready", 32'(upd_ready), 32'(slots.size() == 0));
        check("px_we", 32'(px_we), 32'(ew));
        if (ew) begin
            check("px_addr", 32'(px_addr), 32'(slots[0].addr));
            check("px_data", 32'(px_data), 32'(slots[0].data));
        end
        check("frame_done", 32'(frame_done), 32'(fd_exp));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_upd(input int unsigned ox, input int unsigned oy,
                           input int unsigned nx, input int unsigned ny,
                           input int unsigned frac);
        old_x = {16'(ox), 16'(frac)};
        old_y = {16'(oy), 16'(frac ^ 32'h1234)};
        new_x = {16'(nx), 16'(frac + 32'd7)};
        new_y = {16'(ny), 16'(frac ^ 32'h0F0F)};
    endtask

    initial begin
        int unsigned ox, oy, nx, ny;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(upd_ready), 32'd1);
        check("rst_we", 32'(px_we), 32'd0);
        check("rst_addr", 32'(px_addr), 32'd0);
        check("rst_data", 32'(px_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Normal update (10,20) -> (11,21), grant high.
        set_upd(10, 20, 11, 21, 32'h8000);
        upd_valid = 1'b1;
        px_grant  = 1'b1;
        tick();
        upd_valid = 1'b0;
`ifndef BOID_PLOT_TRAIL_EN
        check("norm_erase_we", 32'(px_we), 32'd1);
        check("norm_erase_addr", 32'(px_addr), 32'd12810);
        check("norm_erase_data", 32'(px_data), 32'h00);
`else
        check("trail_erase_we", 32'(px_we), 32'd0);
`endif
        tick();
        check("norm_draw_addr", 32'(px_addr), 32'd13451);
        check("norm_draw_data", 32'(px_data), 32'hFF);
        tick();
        check("norm_ready_k3", 32'(upd_ready), 32'd1);

        // Same update with grant held low for three ERASE cycles.
        set_upd(10, 20, 11, 21, 32'h0100);
        upd_valid = 1'b1;
        px_grant  = 1'b0;
        tick();
        upd_valid = 1'b0;
`ifndef BOID_PLOT_TRAIL_EN
        for (int i = 0; i < 3; i++) begin
            check("stall_we", 32'(px_we), 32'd1);
            check("stall_addr", 32'(px_addr), 32'd12810);
            check("stall_data", 32'(px_data), 32'h00);
            if (i < 2) tick();
        end
        px_grant = 1'b1;
        tick();
        check("stall_draw_addr", 32'(px_addr), 32'd13451);
        tick();
        check("stall_frame_done", 32'(frame_done), 32'd1);
`else
        repeat (2) tick();
        px_grant = 1'b1;
        repeat (3) tick();
`endif

        // Clipped new position (700,5): erase only.
        set_upd(3, 4, 700, 5, 32'h4444);
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
`ifndef BOID_PLOT_TRAIL_EN
        check("clip_erase_addr", 32'(px_addr), 32'd2563);
`endif
        tick();
        check("clip_draw_we", 32'(px_we), 32'd0);
        tick();
        check("clip_ready", 32'(upd_ready), 32'd1);
        check("clip_frame_done", 32'(frame_done), 32'd0);

        // Same integer pixel (50,50), differing fractions: draw only.
        set_upd(50, 50, 50, 50, 32'h1357);
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        check("same_erase_we", 32'(px_we), 32'd0);
        tick();
        check("same_draw_we", 32'(px_we), 32'd1);
        check("same_draw_addr", 32'(px_addr), 32'd32050);
        tick();
        check("same_frame_done", 32'(frame_done), 32'd1);

        // Reset while a stalled write is outstanding.
        set_upd(10, 20, 11, 21, 32'h2222);
        upd_valid = 1'b1;
        px_grant  = 1'b0;
        tick();
        upd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(px_we), 32'd0);
        check("midrst_ready", 32'(upd_ready), 32'd1);
        model_step();
        @(negedge clk);
        tick();
        rst_n    = 1'b1;
        px_grant = 1'b1;
        repeat (4) tick();

        // Randomized traffic against the slot model.
        for (int c = 0; c < 800; c++) begin
            upd_valid = 1'($urandom_range(0, 1));
            px_grant  = ($urandom_range(0, 9) < 7);
            ox = $urandom_range(0, 720);
            oy = $urandom_range(0, 540);
            if ($urandom_range(0, 4) == 0) begin
                nx = ox;
                ny = oy;
            end else begin
                nx = $urandom_range(0, 720);
                ny = $urandom_range(0, 540);
            end
            set_upd(ox, oy, nx, ny, $urandom_range(0, 65535));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
